// File: rtl/turn_signal_ctrl.sv
// Turn-signal controller: synchronizes raw switches, divides the clock into enable
// ticks and sequences an active-low command vector for a downstream lamp FSM.
module turn_signal_ctrl #(
    parameter int TICK_DIV     = 4,
    parameter int INIT_TICKS   = 2,
    parameter int CANCEL_TICKS = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hazard_sw,
    input  logic       left_sw,
    input  logic       right_sw,
    output logic       enable,
    output logic [3:0] stimulus,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        LEFT   = 3'd2,
        RIGHT  = 3'd3,
        HAZARD = 3'd4,
        CLEAR  = 3'd5
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [3:0]  INIT_LAST = 4'(INIT_TICKS - 1);
    localparam logic [7:0]  TURN_LAST = 8'(CANCEL_TICKS - 1);

    state_t      state, state_nxt, after, after_nxt;
    logic [2:0]  sync1, sync2, sync3;   // {hazard, left, right}
    logic [15:0] tick_cnt;
    logic [3:0]  init_cnt;
    logic [7:0]  turn_cnt;
    logic        pend_l, pend_r;
    logic        tick, hz, rise_l, rise_r, pl, pr;

    function automatic logic [3:0] stim_of(input state_t s);
        case (s)
            IDLE:    stim_of = 4'b1111;
            LEFT:    stim_of = 4'b0111;
            RIGHT:   stim_of = 4'b1110;
            HAZARD:  stim_of = 4'b1011;
            default: stim_of = 4'b1101;
        endcase
    endfunction

    assign tick   = (tick_cnt == TICK_LAST);
    assign enable = tick;
    assign mode   = state;
    assign hz     = sync2[2];
    assign rise_l = sync2[1] & ~sync3[1];
    assign rise_r = sync2[0] & ~sync3[0];
    // An edge arriving on the tick cycle itself still counts for that decision.
    assign pl     = pend_l | rise_l;
    assign pr     = pend_r | rise_r;

    always_comb begin
        state_nxt = state;
        after_nxt = after;
        if (tick) begin
            case (state)
                INIT:   if (init_cnt == INIT_LAST) state_nxt = IDLE;
                IDLE: begin
                    if (hz)             state_nxt = HAZARD;
                    else if (pl && !pr) state_nxt = LEFT;
                    else if (pr && !pl) state_nxt = RIGHT;
                end
                LEFT: begin
                    if (hz) state_nxt = HAZARD;
                    else if (pl || turn_cnt == TURN_LAST) begin
                        state_nxt = CLEAR;
                        after_nxt = IDLE;
                    end else if (pr) begin
                        state_nxt = CLEAR;
                        after_nxt = RIGHT;
                    end
                end
                RIGHT: begin
                    if (hz) state_nxt = HAZARD;
                    else if (pr || turn_cnt == TURN_LAST) begin
                        state_nxt = CLEAR;
                        after_nxt = IDLE;
                    end else if (pl) begin
                        state_nxt = CLEAR;
                        after_nxt = LEFT;
                    end
                end
                HAZARD: if (!hz) begin
                    state_nxt = CLEAR;
                    after_nxt = IDLE;
                end
                CLEAR:   state_nxt = hz ? HAZARD : after;
                default: state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            tick_cnt <= '0;
            pend_l   <= 1'b0;
            pend_r   <= 1'b0;
            state    <= INIT;
            after    <= IDLE;
            stimulus <= 4'b1101;
            init_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            sync1    <= {hazard_sw, left_sw, right_sw};
            sync2    <= sync1;
            sync3    <= sync2;
            tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
            pend_l   <= tick ? 1'b0 : pl;
            pend_r   <= tick ? 1'b0 : pr;
            if (tick) begin
                state    <= state_nxt;
                after    <= after_nxt;
                stimulus <= stim_of(state_nxt);
                if (state == INIT && init_cnt != INIT_LAST)
                    init_cnt <= init_cnt + 4'd1;
                // Turn age restarts on every entry and saturates at the cancel point.
                if (state_nxt != state)
                    turn_cnt <= '0;
                else if ((state == LEFT || state == RIGHT) && turn_cnt != TURN_LAST)
                    turn_cnt <= turn_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: directed scenarios then random switch activity,
// every cycle compared against a rule-level reference model.
module tb_turn_signal_ctrl;

    localparam int TD = 4;
    localparam int IT = 2;
    localparam int CT = 12;
    localparam int S_INIT = 0, S_IDLE = 1, S_LEFT = 2, S_RIGHT = 3, S_HAZ = 4, S_CLR = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       hazard_sw = 1'b0, left_sw = 1'b0, right_sw = 1'b0;
    logic       enable;
    logic [3:0] stimulus;
    logic [2:0] mode;

    int checks = 0;
    int errors = 0;

    // reference model state
    int       m_edges, m_st, m_after, m_init_seen, m_age;
    bit       m_pl, m_pr;
    bit [2:0] m_hist[$];

    turn_signal_ctrl #(.TICK_DIV(TD), .INIT_TICKS(IT), .CANCEL_TICKS(CT)) dut (
        .clock(clock), .reset(reset), .hazard_sw(hazard_sw), .left_sw(left_sw),
        .right_sw(right_sw), .enable(enable), .stimulus(stimulus), .mode(mode)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] exp_stim(input int st);
        case (st)
            S_IDLE:  return 4'b1111;
            S_LEFT:  return 4'b0111;
            S_RIGHT: return 4'b1110;
            S_HAZ:   return 4'b1011;
            default: return 4'b1101;
        endcase
    endfunction

    task automatic enter_clear(input int after_st);
        m_st    = S_CLR;
        m_after = after_st;
    endtask

    task automatic model_edge(input bit rst, input bit [2:0] raw);
        bit [2:0] now, prev;
        bit       hz, go_tick;
        int       old_st;
        if (rst) begin
            m_edges = 0; m_st = S_INIT; m_after = S_IDLE; m_init_seen = 0; m_age = 0;
            m_pl = 0; m_pr = 0;
            m_hist = '{3'b000, 3'b000, 3'b000};
            return;
        end
        now     = m_hist[$-1];
        prev    = m_hist[$-2];
        hz      = now[2];
        m_pl    = m_pl | (now[1] & !prev[1]);
        m_pr    = m_pr | (now[0] & !prev[0]);
        go_tick = (m_edges % TD) == TD - 1;
        m_edges++;
        if (go_tick) begin
            old_st = m_st;
            case (m_st)
                S_INIT: begin
                    m_init_seen++;
                    if (m_init_seen >= IT) m_st = S_IDLE;
                end
                S_IDLE: begin
                    if (hz) m_st = S_HAZ;
                    else if (m_pl != m_pr) m_st = m_pl ? S_LEFT : S_RIGHT;
                end
                S_LEFT, S_RIGHT: begin
                    bit same_press  = (m_st == S_LEFT) ? m_pl : m_pr;
                    bit other_press = (m_st == S_LEFT) ? m_pr : m_pl;
                    if (hz) m_st = S_HAZ;
                    else if (same_press || m_age >= CT - 1) enter_clear(S_IDLE);
                    else if (other_press) enter_clear(m_st == S_LEFT ? S_RIGHT : S_LEFT);
                    else m_age++;
                end
                S_HAZ:   if (!hz) enter_clear(S_IDLE);
                default: m_st = hz ? S_HAZ : m_after;
            endcase
            if (m_st != old_st) m_age = 0;
            m_pl = 0;
            m_pr = 0;
        end
        m_hist.push_back(raw);
        void'(m_hist.pop_front());
    endtask

    task automatic compare();
        bit       e_en;
        logic [3:0] e_stim;
        e_en   = (m_edges % TD) == TD - 1;
        e_stim = exp_stim(m_st);
        checks++;
        assert (enable === e_en) else begin
            errors++;
            $error("FAIL enable got=%b want=%b t=%0t", enable, e_en, $time);
        end
        checks++;
        assert (stimulus === e_stim) else begin
            errors++;
            $error("FAIL stimulus got=%b want=%b t=%0t", stimulus, e_stim, $time);
        end
        checks++;
        assert (mode === 3'(m_st)) else begin
            errors++;
            $error("FAIL mode got=%0d want=%0d t=%0t", mode, m_st, $time);
        end
    endtask

    task automatic cyc(input bit r);
        reset = r;
        @(posedge clock);
        #1;
        model_edge(r, {hazard_sw, left_sw, right_sw});
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic press(input bit l, input bit r);
        left_sw  = l;
        right_sw = r;
        run(3);
        left_sw  = 1'b0;
        right_sw = 1'b0;
    endtask

    initial begin
        int lcnt = 0, rcnt = 0;
        // reset, then idle: INIT for two ticks then IDLE
        cyc(1'b1);
        cyc(1'b1);
        run(14);
        // single left press, auto-cancel
        press(1'b1, 1'b0);
        run(60);
        // left, then right switches over, then right again cancels
        press(1'b1, 1'b0);
        run(10);
        press(1'b0, 1'b1);
        run(14);
        press(1'b0, 1'b1);
        run(14);
        // hazard during right turn; turn is not resumed
        press(1'b0, 1'b1);
        run(8);
        hazard_sw = 1'b1;
        run(20);
        hazard_sw = 1'b0;
        run(20);
        // simultaneous left and right in IDLE are discarded
        press(1'b1, 1'b1);
        run(14);
        // reset while LEFT
        press(1'b1, 1'b0);
        run(10);
        checks++;
        assert (mode === 3'd2) else begin
            errors++;
            $error("FAIL left_before_reset got=%0d want=2", mode);
        end
        cyc(1'b1);
        checks++;
        assert (stimulus === 4'b1101 && mode === 3'd0 && enable === 1'b0) else begin
            errors++;
            $error("FAIL mid_reset got=%b/%0d/%b want=1101/0/0", stimulus, mode, enable);
        end
        run(20);
        // random switch activity with rare resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) hazard_sw = ~hazard_sw;
            if (lcnt > 0) begin
                lcnt--;
                if (lcnt == 0) left_sw = 1'b0;
            end else if ($urandom_range(0, 24) == 0) begin
                left_sw = 1'b1;
                lcnt    = int'($urandom_range(1, 5));
            end
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) right_sw = 1'b0;
            end else if ($urandom_range(0, 24) == 0) begin
                right_sw = 1'b1;
                rcnt     = int'($urandom_range(1, 5));
            end
            cyc($urandom_range(0, 799) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
